// File: rtl/key_event_ctrl.sv
// Key event controller: classifies debounced active-low key presses into SHORT/LONG/REPEAT/
// LONG_RELEASE on a shared 1 ms tick and round-robins them onto one valid/ready stream.
// Optional feature macro: KEY_REPEAT_EN (REPEAT events while a key is held past LONG).

package key_event_pkg;
    localparam logic [1:0] EVT_SHORT    = 2'd0;
    localparam logic [1:0] EVT_LONG     = 2'd1;
    localparam logic [1:0] EVT_REPEAT   = 2'd2;
    localparam logic [1:0] EVT_LONG_REL = 2'd3;

    typedef struct packed {
        logic       pend;
        logic [1:0] ptype;
    } pend_t;
endpackage

module key_event_fsm
    import key_event_pkg::*;
#(
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic       tick,
    output logic       emit,
    output logic [1:0] emit_type
);
    if (LONG_MS < 2 || LONG_MS > 65535 || REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_bad_param
        $error("key_event_fsm: LONG_MS/REPEAT_MS out of range");
    end

    localparam logic [15:0] LONG_C = 16'(LONG_MS);

    typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} state_t;

    state_t      state, state_nxt;
    logic        armed;
    logic [15:0] hold_cnt, hold_nxt, hold_inc;

    // Counters saturate rather than wrap so a stuck key can never re-trigger.
    assign hold_inc = (hold_cnt == 16'hFFFF) ? hold_cnt : hold_cnt + 16'd1;

`ifdef KEY_REPEAT_EN
    localparam logic [15:0] REPEAT_C = 16'(REPEAT_MS);
    logic [15:0] rep_cnt, rep_nxt, rep_inc;

    assign rep_inc = (rep_cnt == 16'hFFFF) ? rep_cnt : rep_cnt + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rep_cnt <= '0;
        else     rep_cnt <= rep_nxt;
    end
`endif

    // A key held through reset release stays ignored until it has been seen high once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            armed    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            if (btn_n) armed <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        emit      = 1'b0;
        emit_type = EVT_SHORT;
`ifdef KEY_REPEAT_EN
        rep_nxt   = rep_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (armed && !btn_n) begin
                    state_nxt = S_PRESSED;
                    hold_nxt  = '0;
                end
            end
            S_PRESSED: begin
                if (btn_n) begin
                    emit      = 1'b1;
                    emit_type = EVT_SHORT;
                    state_nxt = S_IDLE;
                end else if (tick) begin
                    hold_nxt = hold_inc;
                    if (hold_inc == LONG_C) begin
                        emit      = 1'b1;
                        emit_type = EVT_LONG;
                        state_nxt = S_HELD;
`ifdef KEY_REPEAT_EN
                        rep_nxt   = '0;
`endif
                    end
                end
            end
            S_HELD: begin
                if (btn_n) begin
                    emit      = 1'b1;
                    emit_type = EVT_LONG_REL;
                    state_nxt = S_IDLE;
                end
`ifdef KEY_REPEAT_EN
                else if (tick) begin
                    if (rep_inc == REPEAT_C) begin
                        emit      = 1'b1;
                        emit_type = EVT_REPEAT;
                        rep_nxt   = '0;
                    end else begin
                        rep_nxt = rep_inc;
                    end
                end
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

module key_event_ctrl
    import key_event_pkg::*;
#(
    parameter int NUM_KEYS  = 4,
    parameter int FREQ      = 50,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200,
    localparam int KW       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] btn_n,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [KW-1:0]       evt_key,
    output logic [1:0]          evt_type,
    output logic                evt_overflow
);
    localparam int TICK_N = FREQ * 1000;
    localparam int TW     = (TICK_N > 1) ? $clog2(TICK_N) : 1;

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(TICK_N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    logic [NUM_KEYS-1:0]       emit, grant, ovf;
    logic [NUM_KEYS-1:0][1:0]  emit_type;
    pend_t [NUM_KEYS-1:0]      pend_q;

    logic          slot_load, sel_found;
    logic [KW-1:0] sel_idx, cand, rr_ptr;

    function automatic logic [KW-1:0] wrap_idx(input logic [KW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_KEYS) s = s - NUM_KEYS;
        return KW'(s);
    endfunction

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_event_fsm #(
            .LONG_MS   (LONG_MS),
            .REPEAT_MS (REPEAT_MS)
        ) u_fsm (
            .clk       (clk),
            .rst       (rst),
            .btn_n     (btn_n[i]),
            .tick      (tick),
            .emit      (emit[i]),
            .emit_type (emit_type[i])
        );

        assign grant[i] = slot_load & sel_found & (sel_idx == KW'(i));
        assign ovf[i]   = emit[i] & pend_q[i].pend & ~grant[i];

        // A new event beats the grant-clear, so an event arriving as the old one leaves is kept.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pend_q[i] <= '0;
            end else if (emit[i]) begin
                pend_q[i].pend  <= 1'b1;
                pend_q[i].ptype <= emit_type[i];
            end else if (grant[i]) begin
                pend_q[i].pend <= 1'b0;
            end
        end
    end

    assign slot_load = ~evt_valid | evt_ready;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            cand = wrap_idx(rr_ptr, k);
            if (!sel_found && pend_q[cand].pend) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid    <= 1'b0;
            evt_key      <= '0;
            evt_type     <= '0;
            evt_overflow <= 1'b0;
            rr_ptr       <= '0;
        end else begin
            evt_overflow <= |ovf;
            if (slot_load) begin
                evt_valid <= sel_found;
                if (sel_found) begin
                    evt_key  <= sel_idx;
                    evt_type <= pend_q[sel_idx].ptype;
                    rr_ptr   <= wrap_idx(sel_idx, 1);
                end
            end
        end
    end
endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: FREQ=1 (tick every 1000 clocks), 4 keys, LONG_MS=5, REPEAT_MS=2.
// REPEAT expectations follow whether KEY_REPEAT_EN is defined for the build.

module tb_key_event_ctrl;
    localparam int NK = 4;
    localparam int KW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] btn_n = '1;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [KW-1:0] evt_key;
    logic [1:0]    evt_type;
    logic          evt_overflow;

    always #5 clk = ~clk;

    key_event_ctrl #(
        .NUM_KEYS  (NK),
        .FREQ      (1),
        .LONG_MS   (5),
        .REPEAT_MS (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_n        (btn_n),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_key      (evt_key),
        .evt_type     (evt_type),
        .evt_overflow (evt_overflow)
    );

    typedef struct packed {
        logic [31:0] t;
        logic [1:0]  key;
        logic [1:0]  typ;
    } rec_t;

    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    int   ovf_cnt = 0;
    rec_t log_q[$];
    rec_t mon_r;

    always @(posedge clk) cyc <= cyc + 1;

    // Transfers are logged one half-cycle before the edge that completes them.
    always @(negedge clk) begin
        if (!rst) begin
            if (evt_valid && evt_ready) begin
                mon_r.t   = cyc;
                mon_r.key = evt_key;
                mon_r.typ = evt_type;
                log_q.push_back(mon_r);
            end
            if (evt_overflow) ovf_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic rec_t at(input int i);
        rec_t r;
        r.t   = '1;
        r.key = '0;
        r.typ = '0;
        if (i < log_q.size()) r = log_q[i];
        return r;
    endfunction

    int c0, r0, tl;

    initial begin
        // reset state
        step(3);
        chk("rst_valid", evt_valid, 0);
        chk("rst_key", evt_key, 0);
        chk("rst_type", evt_type, 0);
        chk("rst_ovf", evt_overflow, 0);
        rst = 1'b0;
        step(5);

        // round-robin with backpressure: keys 0 and 3 released together
        evt_ready = 1'b0;
        btn_n[0] = 1'b0;
        btn_n[3] = 1'b0;
        step(10);
        log_q.delete();
        btn_n = '1;
        step(3);
        chk("rr_valid", evt_valid, 1);
        chk("rr_key0", evt_key, 0);
        chk("rr_type0", evt_type, 0);
        step(10);
        chk("rr_stable_valid", evt_valid, 1);
        chk("rr_stable_key", evt_key, 0);
        evt_ready = 1'b1;
        step(1);
        chk("rr_next_key", evt_key, 3);
        chk("rr_next_valid", evt_valid, 1);
        step(1);
        evt_ready = 1'b0;
        step(2);
        chk("rr_drain_valid", evt_valid, 0);
        chk("rr_hold_key", evt_key, 3);
        chk("rr_count", log_q.size(), 2);
        chk("rr_first", at(0).key, 0);
        chk("rr_second", at(1).key, 3);

        // short press on key 1
        evt_ready = 1'b1;
        log_q.delete();
        btn_n[1] = 1'b0;
        step(2500);
        r0 = cyc;
        btn_n[1] = 1'b1;
        step(10);
        chk("short_count", log_q.size(), 1);
        chk("short_key", at(0).key, 1);
        chk("short_type", at(0).typ, 0);
        chk("short_lat", at(0).t, r0 + 2);

        // long hold on key 2
        log_q.delete();
        c0 = cyc;
        btn_n[2] = 1'b0;
        step(10000);
        r0 = cyc;
        btn_n[2] = 1'b1;
        step(10);
        tl = int'(at(0).t);
        chk("long_key", at(0).key, 2);
        chk("long_type", at(0).typ, 1);
        chk("long_win", (tl - c0 >= 4003) && (tl - c0 <= 5002), 1);
`ifdef KEY_REPEAT_EN
        chk("long_count", log_q.size(), 4);
        chk("rep1_type", at(1).typ, 2);
        chk("rep1_time", at(1).t, tl + 2000);
        chk("rep2_type", at(2).typ, 2);
        chk("rep2_time", at(2).t, tl + 4000);
        chk("lrel_type", at(3).typ, 3);
        chk("lrel_time", at(3).t, r0 + 2);
        chk("lrel_key", at(3).key, 2);
`else
        chk("long_count", log_q.size(), 2);
        chk("lrel_type", at(1).typ, 3);
        chk("lrel_time", at(1).t, r0 + 2);
        chk("lrel_key", at(1).key, 2);
`endif

        // overflow: key 0 occupies the slot, key 1 pending, key 1 again
        evt_ready = 1'b0;
        log_q.delete();
        ovf_cnt = 0;
        btn_n[0] = 1'b0; step(5);
        btn_n[0] = 1'b1; step(5);
        btn_n[1] = 1'b0; step(5);
        btn_n[1] = 1'b1; step(5);
        chk("ovf_none_yet", ovf_cnt, 0);
        chk("ovf_slot_key", evt_key, 0);
        btn_n[1] = 1'b0; step(5);
        btn_n[1] = 1'b1; step(5);
        chk("ovf_pulses", ovf_cnt, 1);
        chk("ovf_low_after", evt_overflow, 0);
        evt_ready = 1'b1;
        step(8);
        chk("ovf_count", log_q.size(), 2);
        chk("ovf_first_key", at(0).key, 0);
        chk("ovf_second_key", at(1).key, 1);
        chk("ovf_second_type", at(1).typ, 0);
        chk("ovf_drained", evt_valid, 0);

        // reset mid-press on key 0
        log_q.delete();
        btn_n[0] = 1'b0;
        step(20);
        rst = 1'b1;
        step(2);
        chk("mrst_valid", evt_valid, 0);
        chk("mrst_key", evt_key, 0);
        chk("mrst_type", evt_type, 0);
        chk("mrst_ovf", evt_overflow, 0);
        rst = 1'b0;
        step(50);
        btn_n[0] = 1'b1;
        step(10);
        chk("mrst_no_event", log_q.size(), 0);
        btn_n[0] = 1'b0;
        step(10);
        r0 = cyc;
        btn_n[0] = 1'b1;
        step(6);
        chk("mrst_repress_count", log_q.size(), 1);
        chk("mrst_repress_key", at(0).key, 0);
        chk("mrst_repress_type", at(0).typ, 0);
        chk("mrst_repress_lat", at(0).t, r0 + 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
